// File: rtl/decimador_pdm_if.sv
// Bundle of the PDM decimator's run control, stream input and result outputs.
// The master drives enable/bitIn; the slave (the decimator) drives the result side.
interface decimador_pdm_if #(
    parameter int width = 4
);
    logic             enable;
    logic             bitIn;
    logic [width-1:0] datoOut;
    logic             datoValido;
    logic             ocupado;

    modport master (
        output enable,
        output bitIn,
        input  datoOut,
        input  datoValido,
        input  ocupado
    );

    modport slave (
        input  enable,
        input  bitIn,
        output datoOut,
        output datoValido,
        output ocupado
    );
endinterface

// File: rtl/decimador_pdm.sv
// PDM decimator: counts ones over 2^ventanaLog2 samples and emits a saturated width-bit word.
// Optional macro PDM_COMPLEMENTO2_EN converts the offset-binary word to two's complement.
module decimador_pdm #(
    parameter int width       = 4,
    parameter int ventanaLog2 = 4
) (
    input  logic             clk44kHz,
    input  logic             reset,
    decimador_pdm_if.slave   bus
);

    typedef enum logic {
        REPOSO,
        ACUMULA
    } estado_t;

    localparam int SHIFT = ventanaLog2 - width;
    localparam logic [ventanaLog2:0] MAXESC  = (ventanaLog2 + 1)'((1 << width) - 1);
    localparam logic [width-1:0]     MSBMASK = width'(1) << (width - 1);

    estado_t                estado;
    logic [ventanaLog2-1:0] cuenta;
    logic [ventanaLog2:0]   acum;

    logic [ventanaLog2:0]   bitExt;
    logic [ventanaLog2:0]   total;
    logic [ventanaLog2:0]   escalado;
    logic [width-1:0]       saturado;
    logic [width-1:0]       palabra;
    logic                   finVentana;

    // Window-end arithmetic: the sample arriving on the last edge is folded in before scaling.
    always_comb begin
        bitExt     = {{ventanaLog2{1'b0}}, bus.bitIn};
        total      = acum + bitExt;
        escalado   = total >> SHIFT;
        finVentana = (cuenta == {ventanaLog2{1'b1}});
        if (escalado > MAXESC) begin
            saturado = {width{1'b1}};
        end else begin
            saturado = escalado[width-1:0];
        end
`ifdef PDM_COMPLEMENTO2_EN
        palabra = saturado ^ MSBMASK;
`else
        palabra = saturado;
`endif
    end

    // enable low is checked first, so dropping it on the window-end edge discards the window.
    always_ff @(posedge clk44kHz or posedge reset) begin
        if (reset) begin
            estado         <= REPOSO;
            cuenta         <= '0;
            acum           <= '0;
            bus.datoOut    <= '0;
            bus.datoValido <= 1'b0;
            bus.ocupado    <= 1'b0;
        end else begin
            bus.datoValido <= 1'b0;
            if (!bus.enable) begin
                estado      <= REPOSO;
                cuenta      <= '0;
                acum        <= '0;
                bus.ocupado <= 1'b0;
            end else begin
                case (estado)
                    REPOSO: begin
                        estado      <= ACUMULA;
                        bus.ocupado <= 1'b1;
                        acum        <= bitExt;
                        cuenta      <= ventanaLog2'(1);
                    end
                    ACUMULA: begin
                        bus.ocupado <= 1'b1;
                        if (finVentana) begin
                            bus.datoOut    <= palabra;
                            bus.datoValido <= 1'b1;
                            acum           <= '0;
                            cuenta         <= '0;
                        end else begin
                            acum   <= total;
                            cuenta <= cuenta + 1'b1;
                        end
                    end
                    default: begin
                        estado      <= REPOSO;
                        bus.ocupado <= 1'b0;
                        acum        <= '0;
                        cuenta      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decimador_pdm.sv
// Self-checking bench for decimador_pdm: a 16-sample instance and a 64-sample instance,
// each window's expected word derived from its ones count (honours PDM_COMPLEMENTO2_EN).
module tb_decimador_pdm;

    logic clk44kHz = 1'b0;
    logic reset    = 1'b1;

    int checkCount = 0;
    int passCount  = 0;

    logic [3:0] lastA = 4'd0;
    logic [3:0] lastB = 4'd0;

    decimador_pdm_if #(.width(4)) busA ();
    decimador_pdm_if #(.width(4)) busB ();

    decimador_pdm #(.width(4), .ventanaLog2(4)) dutA (
        .clk44kHz (clk44kHz),
        .reset    (reset),
        .bus      (busA)
    );

    decimador_pdm #(.width(4), .ventanaLog2(6)) dutB (
        .clk44kHz (clk44kHz),
        .reset    (reset),
        .bus      (busB)
    );

    always #5 clk44kHz = ~clk44kHz;

    // Expected word for a window containing 'ones' ones out of 2^logN samples.
    function automatic logic [3:0] expectedWord(input int ones, input int logN);
        int esc;
        esc = ones >> (logN - 4);
        if (esc > 15) esc = 15;
`ifdef PDM_COMPLEMENTO2_EN
        esc = esc ^ 8;
`endif
        return 4'(esc);
    endfunction

    task automatic tick();
        @(posedge clk44kHz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        busA.enable = 1'b0; busA.bitIn = 1'b0;
        busB.enable = 1'b0; busB.bitIn = 1'b0;
        tick(); tick();
        checkCount++; if (busA.datoOut !== 4'd0) $display("[TB] FAIL reset_datoOut got %0d want 0", busA.datoOut); else passCount++;
        checkCount++; if (busA.datoValido !== 1'b0) $display("[TB] FAIL reset_datoValido got %0b want 0", busA.datoValido); else passCount++;
        checkCount++; if (busA.ocupado !== 1'b0) $display("[TB] FAIL reset_ocupado got %0b want 0", busA.ocupado); else passCount++;
        checkCount++; if (busB.datoOut !== 4'd0) $display("[TB] FAIL reset_datoOutB got %0d want 0", busB.datoOut); else passCount++;
        reset = 1'b0;
        tick();
        checkCount++; if (busA.ocupado !== 1'b0) $display("[TB] FAIL idle_ocupado got %0b want 0", busA.ocupado); else passCount++;
    endtask

    task automatic test_all_ones();
        busA.enable = 1'b1; busA.bitIn = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            checkCount++; if (busA.datoValido !== (e == 16)) $display("[TB] FAIL ones_strobe edge %0d got %0b want %0b", e, busA.datoValido, (e == 16)); else passCount++;
            checkCount++; if (busA.ocupado !== 1'b1) $display("[TB] FAIL ones_ocupado edge %0d got %0b want 1", e, busA.ocupado); else passCount++;
        end
        lastA = expectedWord(16, 4);
        checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL ones_datoOut got %0d want %0d", busA.datoOut, lastA); else passCount++;
        busA.enable = 1'b0;
        tick();
        checkCount++; if (busA.datoValido !== 1'b0) $display("[TB] FAIL ones_strobe_after got %0b want 0", busA.datoValido); else passCount++;
    endtask

    task automatic test_patterns();
        int ones;
        for (int w = 0; w < 3; w++) begin
            ones = 0;
            busA.enable = 1'b1;
            for (int e = 1; e <= 16; e++) begin
                busA.bitIn = (w < 2) ? ((e % 2) == 1) : 1'b0;
                ones += int'(busA.bitIn);
                tick();
                checkCount++; if (busA.datoValido !== (e == 16)) $display("[TB] FAIL pat_strobe win %0d edge %0d got %0b want %0b", w, e, busA.datoValido, (e == 16)); else passCount++;
                if (e < 16) begin
                    checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL pat_hold win %0d edge %0d got %0d want %0d", w, e, busA.datoOut, lastA); else passCount++;
                end
            end
            lastA = expectedWord(ones, 4);
            checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL pat_datoOut win %0d got %0d want %0d", w, busA.datoOut, lastA); else passCount++;
        end
        busA.enable = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int ones;
        int thr;
        busA.enable = 1'b1;
        for (int w = 0; w < 5; w++) begin
            ones = 0;
            thr  = $urandom_range(0, 16);
            for (int e = 1; e <= 16; e++) begin
                busA.bitIn = ($urandom_range(0, 15) < thr);
                ones += int'(busA.bitIn);
                tick();
                checkCount++; if (busA.datoValido !== (e == 16)) $display("[TB] FAIL b2b_strobe win %0d edge %0d got %0b want %0b", w, e, busA.datoValido, (e == 16)); else passCount++;
            end
            lastA = expectedWord(ones, 4);
            checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL b2b_datoOut win %0d ones %0d got %0d want %0d", w, ones, busA.datoOut, lastA); else passCount++;
        end
        busA.enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        busA.enable = 1'b1; busA.bitIn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checkCount++; if (busA.datoValido !== 1'b0) $display("[TB] FAIL abort_strobe edge %0d got %0b want 0", e, busA.datoValido); else passCount++;
        end
        busA.enable = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checkCount++; if (busA.ocupado !== 1'b0) $display("[TB] FAIL abort_ocupado edge %0d got %0b want 0", e, busA.ocupado); else passCount++;
            checkCount++; if (busA.datoValido !== 1'b0) $display("[TB] FAIL abort_nostrobe edge %0d got %0b want 0", e, busA.datoValido); else passCount++;
            checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL abort_hold edge %0d got %0d want %0d", e, busA.datoOut, lastA); else passCount++;
        end
        busA.enable = 1'b1; busA.bitIn = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            checkCount++; if (busA.datoValido !== (e == 16)) $display("[TB] FAIL rerise_strobe edge %0d got %0b want %0b", e, busA.datoValido, (e == 16)); else passCount++;
        end
        lastA = expectedWord(0, 4);
        checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL rerise_datoOut got %0d want %0d", busA.datoOut, lastA); else passCount++;
        // Next window runs 15 samples, then enable drops on what would be the window-end edge.
        for (int e = 1; e <= 15; e++) begin
            busA.bitIn = 1'($urandom_range(0, 1));
            tick();
        end
        busA.enable = 1'b0; busA.bitIn = 1'b1;
        tick();
        checkCount++; if (busA.datoValido !== 1'b0) $display("[TB] FAIL endabort_strobe got %0b want 0", busA.datoValido); else passCount++;
        checkCount++; if (busA.ocupado !== 1'b0) $display("[TB] FAIL endabort_ocupado got %0b want 0", busA.ocupado); else passCount++;
        checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL endabort_hold got %0d want %0d", busA.datoOut, lastA); else passCount++;
    endtask

    task automatic test_async_reset();
        busA.enable = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            busA.bitIn = (e <= 12);
            tick();
        end
        lastA = expectedWord(12, 4);
        checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL pre_reset_datoOut got %0d want %0d", busA.datoOut, lastA); else passCount++;
        busA.bitIn = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        #2 reset = 1'b1;
        #1;
        checkCount++; if (busA.datoOut !== 4'd0) $display("[TB] FAIL async_datoOut got %0d want 0", busA.datoOut); else passCount++;
        checkCount++; if (busA.datoValido !== 1'b0) $display("[TB] FAIL async_datoValido got %0b want 0", busA.datoValido); else passCount++;
        checkCount++; if (busA.ocupado !== 1'b0) $display("[TB] FAIL async_ocupado got %0b want 0", busA.ocupado); else passCount++;
        #1 reset = 1'b0;
        lastA = 4'd0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            checkCount++; if (busA.datoValido !== (e == 16)) $display("[TB] FAIL postreset_strobe edge %0d got %0b want %0b", e, busA.datoValido, (e == 16)); else passCount++;
        end
        lastA = expectedWord(16, 4);
        checkCount++; if (busA.datoOut !== lastA) $display("[TB] FAIL postreset_datoOut got %0d want %0d", busA.datoOut, lastA); else passCount++;
        busA.enable = 1'b0;
        tick();
    endtask

    task automatic test_wide_window();
        int ones;
        busB.enable = 1'b1;
        for (int w = 0; w < 3; w++) begin
            ones = 0;
            for (int e = 1; e <= 64; e++) begin
                case (w)
                    0:       busB.bitIn = ((e % 2) == 0);
                    1:       busB.bitIn = 1'b1;
                    default: busB.bitIn = 1'($urandom_range(0, 1));
                endcase
                ones += int'(busB.bitIn);
                tick();
                checkCount++; if (busB.datoValido !== (e == 64)) $display("[TB] FAIL wide_strobe win %0d edge %0d got %0b want %0b", w, e, busB.datoValido, (e == 64)); else passCount++;
            end
            lastB = expectedWord(ones, 6);
            checkCount++; if (busB.datoOut !== lastB) $display("[TB] FAIL wide_datoOut win %0d ones %0d got %0d want %0d", w, ones, busB.datoOut, lastB); else passCount++;
        end
        busB.enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_wide_window();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
